// File: rtl/display_pkg.sv
// Shared types, source codes and priority helpers for the 7-segment display arbiter.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2,
    SHOW_M = 2'd3
  } disp_state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_M    = 2'd3;

  // Bit order of request/pending vectors is {M, B, A}; M has highest priority.
  function automatic logic [1:0] prio_src(input logic [2:0] pend);
    logic [1:0] code;
    code = SRC_NONE;
    if (pend[2]) begin
      code = SRC_M;
    end else if (pend[1]) begin
      code = SRC_B;
    end else if (pend[0]) begin
      code = SRC_A;
    end else begin
      code = SRC_NONE;
    end
    return code;
  endfunction

  function automatic logic [2:0] src_onehot(input logic [1:0] code);
    logic [2:0] oh;
    case (code)
      SRC_A:   oh = 3'b001;
      SRC_B:   oh = 3'b010;
      SRC_M:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/module_disp_timer.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag (count == N-1).
module module_disp_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(N) + 1;
  localparam logic [W-1:0] TERM = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear dominates, otherwise count up and stick at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (en && (count_q != TERM)) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TERM);

endmodule

// File: rtl/module_display_ctrl.sv
// Display source arbiter: grants A/B/M with a minimum hold time, queues the rest by
// priority (M > B > A) and blanks the display after a quiet period.
module module_display_ctrl #(
  parameter int HOLD_CYCLES = 1000,
  parameter int IDLE_CYCLES = 8000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_m,
  output logic       load_a,
  output logic       load_b,
  output logic       load_m,
  output logic [1:0] src,
  output logic       active,
  output logic       sel_new
);

  import display_pkg::*;

  disp_state_t state_q, state_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  load_q, load_d;
  logic [1:0]  src_q, src_d;
  logic        active_q, active_d;
  logic        sel_new_q, sel_new_d;

  logic [2:0]  req_v;
  logic        any_req;
  logic [1:0]  cur_code;
  logic [2:0]  cur_bit;
  logic [1:0]  next_code;
  logic        restart;
  logic        switch_go;
  logic        timeout;
  logic        hold_clr, hold_en, hold_tc;
  logic        idle_clr, idle_en, idle_tc;

  // Next-state, pending queue and timer controls.
  always_comb begin
    req_v     = {req_m, req_b, req_a};
    any_req   = |req_v;
    cur_code  = state_q;
    cur_bit   = src_onehot(cur_code);
    restart   = (state_q != IDLE) && (|(req_v & cur_bit));
    switch_go = (state_q != IDLE) && hold_tc && (pending_q != 3'b000) && !restart;
    timeout   = (state_q != IDLE) && idle_tc && !any_req && (pending_q == 3'b000);
    state_d   = state_q;
    pending_d = pending_q;
    sel_new_d = 1'b0;
    next_code = SRC_NONE;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          next_code = prio_src(req_v);
          state_d   = disp_state_t'(next_code);
          pending_d = req_v & ~src_onehot(next_code);
          sel_new_d = 1'b1;
        end else begin
          pending_d = 3'b000;
        end
      end
      SHOW_A, SHOW_B, SHOW_M: begin
        // A re-request of the shown source restarts it instead of queueing it.
        pending_d = pending_q | (req_v & ~cur_bit);
        if (restart) begin
          sel_new_d = 1'b1;
        end else if (switch_go) begin
          next_code = prio_src(pending_q);
          state_d   = disp_state_t'(next_code);
          pending_d = pending_d & ~src_onehot(next_code);
          sel_new_d = 1'b1;
        end else if (timeout) begin
          state_d   = IDLE;
          sel_new_d = 1'b1;
        end else begin
          sel_new_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 3'b000;
      end
    endcase
    hold_clr = sel_new_d || (state_q == IDLE);
    hold_en  = (state_q != IDLE);
    idle_clr = sel_new_d || any_req || (state_q == IDLE);
    idle_en  = (state_q != IDLE) && (pending_q == 3'b000);
    load_d   = src_onehot(state_d);
    src_d    = state_d;
    active_d = (state_d != IDLE);
  end

  // FSM state, pending queue and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 3'b000;
      load_q    <= 3'b000;
      src_q     <= SRC_NONE;
      active_q  <= 1'b0;
      sel_new_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      load_q    <= load_d;
      src_q     <= src_d;
      active_q  <= active_d;
      sel_new_q <= sel_new_d;
    end
  end

  module_disp_timer #(.N(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (hold_clr),
    .en    (hold_en),
    .tc    (hold_tc)
  );

  module_disp_timer #(.N(IDLE_CYCLES)) u_idle_timer (
    .clk   (clk),
    .rst_n (rst),
    .clr   (idle_clr),
    .en    (idle_en),
    .tc    (idle_tc)
  );

  assign load_a  = load_q[0];
  assign load_b  = load_q[1];
  assign load_m  = load_q[2];
  assign src     = src_q;
  assign active  = active_q;
  assign sel_new = sel_new_q;

endmodule

// File: tb/tb_module_display_ctrl.sv
// Self-checking bench for module_display_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_module_display_ctrl;

  localparam int HOLD = 4;
  localparam int IDLE = 16;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, req_m;
  logic       load_a, load_b, load_m;
  logic [1:0] src;
  logic       active;
  logic       sel_new;

  int checks = 0;
  int errors = 0;

  // Model: shown source (0 none, 1 A, 2 B, 3 M), queued flags, visible and quiet times.
  int m_src;
  bit m_pend [1:3];
  int m_hold;
  int m_idle;
  bit m_new;

  module_display_ctrl #(.HOLD_CYCLES(HOLD), .IDLE_CYCLES(IDLE)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_m   (req_m),
    .load_a  (load_a),
    .load_b  (load_b),
    .load_m  (load_m),
    .src     (src),
    .active  (active),
    .sel_new (sel_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {load_m, load_b, load_a, src, active, sel_new};
  endfunction

  function automatic logic [6:0] model_vec();
    logic [1:0] s;
    s = 2'(m_src);
    return {(m_src == 3), (m_src == 2), (m_src == 1), s, (m_src != 0), m_new};
  endfunction

  task automatic model_reset();
    m_src = 0;
    m_hold = 0;
    m_idle = 0;
    m_new = 1'b0;
    for (int s = 1; s <= 3; s++) m_pend[s] = 1'b0;
  endtask

  task automatic model_step(input bit ra, input bit rb, input bit rm);
    bit r [1:3];
    bit any_r, any_p;
    int best;
    r[1] = ra; r[2] = rb; r[3] = rm;
    any_r = ra | rb | rm;
    any_p = m_pend[1] | m_pend[2] | m_pend[3];
    best = 0;
    for (int s = 1; s <= 3; s++) if (m_pend[s]) best = s;
    m_new = 1'b0;
    if (m_src == 0) begin
      if (any_r) begin
        for (int s = 1; s <= 3; s++) if (r[s]) m_src = s;
        for (int s = 1; s <= 3; s++) m_pend[s] = r[s] && (s != m_src);
        m_hold = 0; m_idle = 0; m_new = 1'b1;
      end
    end else begin
      for (int s = 1; s <= 3; s++) if (s != m_src && r[s]) m_pend[s] = 1'b1;
      if (r[m_src]) begin
        m_hold = 0; m_idle = 0; m_new = 1'b1;
      end else if (m_hold == HOLD - 1 && any_p) begin
        m_src = best; m_pend[best] = 1'b0;
        m_hold = 0; m_idle = 0; m_new = 1'b1;
      end else if (!any_r && !any_p && m_idle == IDLE - 1) begin
        m_src = 0; m_hold = 0; m_idle = 0; m_new = 1'b1;
      end else begin
        if (m_hold < HOLD - 1) m_hold++;
        if (any_r) m_idle = 0;
        else if (!any_p && m_idle < IDLE - 1) m_idle++;
      end
    end
  endtask

  // One clock: drive requests, advance the model at the edge, sample #1 later.
  task automatic step(input bit ra, input bit rb, input bit rm);
    req_a = ra; req_b = rb; req_m = rm;
    @(posedge clk);
    model_step(ra, rb, rm);
    #1;
    req_a = 1'b0; req_b = 1'b0; req_m = 1'b0;
  endtask

  task automatic reset_dut();
    req_a = 1'b0; req_b = 1'b0; req_m = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_a = 1'b0; req_b = 1'b0; req_m = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== 7'b0000000) begin
      errors++; $display("FAIL reset_state got %b exp %b", dut_vec(), 7'b0000000);
    end
    // A request while in reset must be lost.
    req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== 7'b0000000) begin
        errors++; $display("FAIL reset_req_lost cyc%0d got %b exp %b", i, dut_vec(), 7'b0000000);
      end
    end
  endtask

  task automatic test_single();
    int a_cyc = 0;
    int pulses = 0;
    reset_dut();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== 7'b0010111) begin
      errors++; $display("FAIL single_entry got %b exp %b", dut_vec(), 7'b0010111);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (load_a) a_cyc++;
      if (sel_new) pulses++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL single_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (a_cyc != IDLE - 1 || pulses != 1) begin
      errors++; $display("FAIL single_timeout got a_cyc=%0d pulses=%0d exp %0d 1", a_cyc, pulses, IDLE - 1);
    end
  endtask

  task automatic test_simultaneous();
    int cm = 0, cb = 0, ca = 0, pulses = 0, multi = 0;
    reset_dut();
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (load_m) cm++;
      if (load_b) cb++;
      if (load_a) ca++;
      if (sel_new) pulses++;
      if (32'(load_a) + 32'(load_b) + 32'(load_m) > 1) multi++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL simul_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
      step(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (cm != HOLD || cb != HOLD || ca != IDLE || pulses != 4 || multi != 0) begin
      errors++;
      $display("FAIL simul_counts got m=%0d b=%0d a=%0d pulses=%0d multi=%0d exp %0d %0d %0d 4 0",
               cm, cb, ca, pulses, multi, HOLD, HOLD, IDLE);
    end
  endtask

  task automatic test_late();
    int b_rise = -1, multi = 0;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, i == 2, 1'b0);
      if (load_b && b_rise < 0) b_rise = i;
      if (32'(load_a) + 32'(load_b) + 32'(load_m) > 1) multi++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL late_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (b_rise != HOLD || multi != 0) begin
      errors++; $display("FAIL late_switch got b_rise=%0d multi=%0d exp %0d 0", b_rise, multi, HOLD);
    end
  endtask

  task automatic test_restart();
    int m_cyc = 0, b_rise = -1;
    logic restart_pulse = 1'b0;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, i == 1, (i == 0) || (i == 4));
      if (i == 4) restart_pulse = sel_new && load_m;
      if (load_m) m_cyc++;
      if (load_b && b_rise < 0) b_rise = i;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL restart_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (!restart_pulse || m_cyc != 2 * HOLD || b_rise != 2 * HOLD) begin
      errors++;
      $display("FAIL restart got pulse=%0b m_cyc=%0d b_rise=%0d exp 1 %0d %0d",
               restart_pulse, m_cyc, b_rise, 2 * HOLD, 2 * HOLD);
    end
  endtask

  task automatic test_duplicate();
    int b_sel = 0, b_cyc = 0;
    reset_dut();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, (i == 1) || (i == 2), i == 0);
      if (load_b && sel_new) b_sel++;
      if (load_b) b_cyc++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL dup_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (b_sel != 1 || b_cyc != IDLE || active !== 1'b0) begin
      errors++; $display("FAIL dup_once got b_sel=%0d b_cyc=%0d active=%0b exp 1 %0d 0", b_sel, b_cyc, active, IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int act = 0;
    reset_dut();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== 7'b0101010) begin
      errors++; $display("FAIL rstmid_pre got %b exp %b", dut_vec(), 7'b0101010);
    end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 7'b0000000) begin
      errors++; $display("FAIL rstmid_async got %b exp %b", dut_vec(), 7'b0000000);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (active || load_a) act++;
    end
    checks++;
    if (act != 0) begin
      errors++; $display("FAIL rstmid_no_a got active_cycles=%0d exp 0", act);
    end
  endtask

  task automatic test_random();
    int thr;
    bit ra, rb, rm;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      thr = ((i / 60) % 2 == 0) ? 15 : 1;
      ra = ($urandom_range(0, 99) < thr);
      rb = ($urandom_range(0, 99) < thr);
      rm = ($urandom_range(0, 99) < thr);
      step(ra, rb, rm);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_cyc%0d got %b exp %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0; req_m = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_late();
    test_restart();
    test_duplicate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
